cache_ctrl_nway_fsm: RTL and testbench

- Registered cache controller FSM that replaces the fixed 2-way, 4-word next-state logic with a parametrised N-way, W-word-per-line engine.
- Owns state, word counters and victim selection, and drives the cache-array and memory control strobes directly.
- Sits between the pipeline memory stage, the N cache way banks and the fixed-latency banked main memory.
- Adds three capabilities: pipelined fill with overlapped read-return, round-robin replacement, and protocol error flagging.

---
 rtl/cache_ctrl_pkg.sv | 25 ++
 rtl/cache_victim_sel.sv | 44 ++++
 rtl/cache_ctrl_nway_fsm.sv | 190 +++++++++++++++++++
 tb/tb_cache_ctrl_nway_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the N-way cache controller slice.
package cache_ctrl_pkg;

  localparam int unsigned DEF_WAYS    = 2;
  localparam int unsigned DEF_WORDS   = 4;
  localparam int unsigned DEF_MEM_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    EVICT,
    FILL,
    RETRY
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way picker: lowest invalid way, else the round-robin pointer.
module cache_victim_sel
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WAYS = DEF_WAYS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WAYS-1:0] valid,
  input  logic            advance,
  output logic [WAYS-1:0] victim,
  output logic            all_valid
);

  localparam int unsigned PW = (WAYS > 1) ? clog2(WAYS) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [WAYS-1:0] first_inv;
  logic            found;

  always_comb begin
    first_inv = '0;
    found     = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !valid[i]) begin
        first_inv[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign all_valid = &valid;
  assign victim    = all_valid ? (WAYS'(1) << rr_ptr) : first_inv;

  // Pointer moves only when a full set forced a round-robin pick.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (rr_ptr == PW'(WAYS - 1)) ? '0 : rr_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl_nway_fsm.sv
// N-way, W-word cache controller: compare, writeback, pipelined fill, retry.
module cache_ctrl_nway_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WAYS    = DEF_WAYS,
  parameter int unsigned WORDS   = DEF_WORDS,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [WAYS-1:0]           hit,
  input  logic [WAYS-1:0]           valid,
  input  logic [WAYS-1:0]           dirty,
  output logic [WAYS-1:0]           way_sel,
  output logic                      cache_comp,
  output logic                      cache_write,
  output logic                      cache_valid_in,
  output logic [clog2(WORDS)-1:0]   cache_offset,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [clog2(WORDS)-1:0]   mem_offset,
  output logic                      mem_tag_sel,
  output logic                      done,
  output logic                      cache_hit,
  output logic                      stall,
  output logic                      err
);

  localparam int unsigned OW        = clog2(WORDS);
  localparam int unsigned CW        = clog2(WORDS + MEM_LAT) + 1;
  localparam int unsigned FILL_LAST = WORDS + MEM_LAT - 1;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            op_wr, op_wr_n;
  logic [WAYS-1:0] victim, victim_n, vsel;
  logic            all_valid, advance, any_hit;
  logic            err_q, err_n;

  logic [WAYS-1:0] way_sel_n;
  logic            cache_comp_n, cache_write_n, valid_in_n;
  logic [OW-1:0]   cache_offset_n, mem_offset_n;
  logic            mem_rd_n, mem_wr_n, tag_sel_n;

  cache_victim_sel #(.WAYS(WAYS)) u_victim (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .advance   (advance),
    .victim    (vsel),
    .all_valid (all_valid)
  );

  assign any_hit = |(hit & valid);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_wr_n  = op_wr;
    victim_n = victim;
    advance  = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          if (rd ^ wr) begin
            state_n = COMPARE;
            op_wr_n = wr;
          end else if (rd && wr) begin
            err_n = 1'b1;
          end
        end
      end
      COMPARE: begin
        if (any_hit) begin
          state_n = IDLE;
        end else begin
          victim_n = vsel;
          advance  = all_valid;
          cnt_n    = '0;
          state_n  = (|(vsel & valid & dirty)) ? EVICT : FILL;
        end
      end
      EVICT: begin
        if (cnt == CW'(WORDS - 1)) begin
          cnt_n   = '0;
          state_n = FILL;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FILL: begin
        if (cnt == CW'(FILL_LAST)) begin
          cnt_n   = '0;
          state_n = RETRY;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RETRY:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they leave a register.
  always_comb begin
    way_sel_n      = '0;
    cache_comp_n   = 1'b0;
    cache_write_n  = 1'b0;
    valid_in_n     = 1'b0;
    cache_offset_n = '0;
    mem_rd_n       = 1'b0;
    mem_wr_n       = 1'b0;
    mem_offset_n   = '0;
    tag_sel_n      = 1'b0;
    case (state_n)
      COMPARE, RETRY: begin
        way_sel_n     = '1;
        cache_comp_n  = 1'b1;
        cache_write_n = op_wr_n;
      end
      EVICT: begin
        way_sel_n      = victim_n;
        cache_offset_n = OW'(cnt_n);
        mem_wr_n       = 1'b1;
        mem_offset_n   = OW'(cnt_n);
        tag_sel_n      = 1'b1;
      end
      FILL: begin
        if (cnt_n < CW'(WORDS)) begin
          mem_rd_n     = 1'b1;
          mem_offset_n = OW'(cnt_n);
        end
        // Valid goes in with the last word so an aborted fill stays invalid.
        if (cnt_n >= CW'(MEM_LAT)) begin
          way_sel_n      = victim_n;
          cache_write_n  = 1'b1;
          cache_offset_n = OW'(cnt_n - CW'(MEM_LAT));
          valid_in_n     = (cnt_n == CW'(FILL_LAST));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op_wr          <= 1'b0;
      victim         <= '0;
      err_q          <= 1'b0;
      stall          <= 1'b0;
      way_sel        <= '0;
      cache_comp     <= 1'b0;
      cache_write    <= 1'b0;
      cache_valid_in <= 1'b0;
      cache_offset   <= '0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_offset     <= '0;
      mem_tag_sel    <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      op_wr          <= op_wr_n;
      victim         <= victim_n;
      err_q          <= err_n;
      stall          <= (state_n != IDLE);
      way_sel        <= way_sel_n;
      cache_comp     <= cache_comp_n;
      cache_write    <= cache_write_n;
      cache_valid_in <= valid_in_n;
      cache_offset   <= cache_offset_n;
      mem_rd         <= mem_rd_n;
      mem_wr         <= mem_wr_n;
      mem_offset     <= mem_offset_n;
      mem_tag_sel    <= tag_sel_n;
    end
  end

  // Completion depends on the tag result seen in the same compare cycle.
  assign cache_hit = (state == COMPARE) && any_hit;
  assign done      = cache_hit || (state == RETRY);
  assign err       = err_q || ((state == RETRY) && !(|hit));

endmodule

// File: tb/tb_cache_ctrl_nway_fsm.sv
// Directed bench: default 2-way/4-word instance plus a 4-way/8-word/lat-3 instance.
module tb_cache_ctrl_nway_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst, enable, rd, wr;
  logic [1:0] hit, valid, dirty, way_sel;
  logic       cache_comp, cache_write, cache_valid_in;
  logic [1:0] cache_offset, mem_offset;
  logic       mem_rd, mem_wr, mem_tag_sel, done, cache_hit, stall, err;

  logic       p_enable, p_rd, p_wr;
  logic [3:0] p_hit, p_valid, p_dirty, p_way_sel;
  logic       p_cache_comp, p_cache_write, p_cache_valid_in;
  logic [2:0] p_cache_offset, p_mem_offset;
  logic       p_mem_rd, p_mem_wr, p_mem_tag_sel, p_done, p_cache_hit, p_stall, p_err;

  int         n, fill_cycles, vin_cnt;
  logic [3:0] vic;
  logic [2:0] vin_off;

  cache_ctrl_nway_fsm dut (
    .clk(clk), .rst(rst), .enable(enable), .rd(rd), .wr(wr),
    .hit(hit), .valid(valid), .dirty(dirty),
    .way_sel(way_sel), .cache_comp(cache_comp), .cache_write(cache_write),
    .cache_valid_in(cache_valid_in), .cache_offset(cache_offset),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_offset(mem_offset),
    .mem_tag_sel(mem_tag_sel), .done(done), .cache_hit(cache_hit),
    .stall(stall), .err(err)
  );

  cache_ctrl_nway_fsm #(.WAYS(4), .WORDS(8), .MEM_LAT(3)) dut_p (
    .clk(clk), .rst(rst), .enable(p_enable), .rd(p_rd), .wr(p_wr),
    .hit(p_hit), .valid(p_valid), .dirty(p_dirty),
    .way_sel(p_way_sel), .cache_comp(p_cache_comp), .cache_write(p_cache_write),
    .cache_valid_in(p_cache_valid_in), .cache_offset(p_cache_offset),
    .mem_rd(p_mem_rd), .mem_wr(p_mem_wr), .mem_offset(p_mem_offset),
    .mem_tag_sel(p_mem_tag_sel), .done(p_done), .cache_hit(p_cache_hit),
    .stall(p_stall), .err(p_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Six FILL cycles of the default instance: reads at c=0..3, writes at c=2..5.
  task automatic fill_default(input logic [1:0] vic_exp, input string tag);
    for (int c = 0; c < 6; c++) begin
      tick();
      check({tag, "_mem_rd"}, 32'(mem_rd), 32'(c < 4));
      if (c < 4) check({tag, "_mem_off"}, 32'(mem_offset), 32'(c));
      check({tag, "_cwr"}, 32'(cache_write), 32'(c >= 2));
      if (c >= 2) begin
        check({tag, "_c_off"}, 32'(cache_offset), 32'(c - 2));
        check({tag, "_way"}, 32'(way_sel), 32'(vic_exp));
      end
      check({tag, "_vin"}, 32'(cache_valid_in), 32'(c == 5));
      check({tag, "_done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rd = 1'b0; wr = 1'b0;
    hit = '0; valid = '0; dirty = '0;
    p_enable = 1'b0; p_rd = 1'b0; p_wr = 1'b0;
    p_hit = '0; p_valid = '0; p_dirty = '0;
    tick(); tick();
    check("rst_way_sel", 32'(way_sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem", 32'({mem_rd, mem_wr}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Load hit on way 0
    enable = 1'b1; rd = 1'b1; hit = 2'b01; valid = 2'b11;
    tick(); enable = 1'b0;
    check("hit_done", 32'(done), 32'd1);
    check("hit_cache_hit", 32'(cache_hit), 32'd1);
    check("hit_way_sel", 32'(way_sel), 32'h3);
    check("hit_comp", 32'(cache_comp), 32'd1);
    check("hit_mem", 32'({mem_rd, mem_wr}), 32'd0);
    tick();
    check("hit_idle", 32'({stall, done}), 32'd0);

    // Clean load miss, way 1 invalid; tag matches way 1 on retry
    enable = 1'b1; rd = 1'b1; wr = 1'b0; hit = 2'b10; valid = 2'b01; dirty = 2'b00;
    tick(); enable = 1'b0;
    check("cm_cmp_done", 32'(done), 32'd0);
    check("cm_cmp_way", 32'(way_sel), 32'h3);
    fill_default(2'b10, "cm");
    tick();
    check("cm_done", 32'(done), 32'd1);
    check("cm_cache_hit", 32'(cache_hit), 32'd0);
    check("cm_err", 32'(err), 32'd0);
    tick();
    check("cm_idle", 32'(stall), 32'd0);

    // Dirty store miss, full set, rr_ptr=0 -> way 0 evicted
    enable = 1'b1; rd = 1'b0; wr = 1'b1; hit = 2'b00; valid = 2'b11; dirty = 2'b11;
    tick(); enable = 1'b0;
    check("dm_cmp_cwr", 32'(cache_write), 32'd1);
    check("dm_cmp_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dm_mem_wr", 32'(mem_wr), 32'd1);
      check("dm_tag_sel", 32'(mem_tag_sel), 32'd1);
      check("dm_mem_off", 32'(mem_offset), 32'(i));
      check("dm_c_off", 32'(cache_offset), 32'(i));
      check("dm_way", 32'(way_sel), 32'h1);
      check("dm_ev_cwr", 32'(cache_write), 32'd0);
    end
    hit = 2'b01;
    fill_default(2'b01, "dm");
    tick();
    check("dm_done", 32'(done), 32'd1);
    check("dm_cache_hit", 32'(cache_hit), 32'd0);
    check("dm_retry_cwr", 32'(cache_write), 32'd1);
    check("dm_err", 32'(err), 32'd0);
    tick();
    check("dm_idle", 32'(stall), 32'd0);

    // Next full-set miss takes way 1; no tag match on retry flags err
    enable = 1'b1; rd = 1'b1; wr = 1'b0; hit = 2'b00; valid = 2'b11; dirty = 2'b00;
    tick(); enable = 1'b0;
    fill_default(2'b10, "rr");
    tick();
    check("rr_done", 32'(done), 32'd1);
    check("rr_err", 32'(err), 32'd1);
    tick();
    check("rr_err_clr", 32'(err), 32'd0);

    // Illegal rd&wr request
    enable = 1'b1; rd = 1'b1; wr = 1'b1;
    tick(); enable = 1'b0; rd = 1'b0; wr = 1'b0;
    check("ill_err", 32'(err), 32'd1);
    check("ill_stall", 32'(stall), 32'd0);
    tick();
    check("ill_err_clr", 32'(err), 32'd0);
    check("ill_stall2", 32'(stall), 32'd0);

    // Reset in third FILL cycle after rr_ptr advanced to 1
    enable = 1'b1; rd = 1'b1; hit = 2'b00; valid = 2'b11; dirty = 2'b00;
    tick(); enable = 1'b0;
    tick(); tick(); tick();
    check("rs_pre_cwr", 32'(cache_write), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("rs_mem_rd", 32'(mem_rd), 32'd0);
    check("rs_cwr", 32'(cache_write), 32'd0);
    check("rs_stall", 32'(stall), 32'd0);
    check("rs_way", 32'(way_sel), 32'd0);
    enable = 1'b1;
    tick(); enable = 1'b0;
    tick(); tick(); tick();
    check("rs_rr_way", 32'(way_sel), 32'h1);
    hit = 2'b01;
    tick(); tick(); tick(); tick();
    check("rs_done", 32'(done), 32'd1);
    check("rs_err", 32'(err), 32'd0);
    tick();

    // 4-way/8-word/lat-3 clean miss, valid=1011 -> way 2
    p_enable = 1'b1; p_rd = 1'b1; p_valid = 4'b1011; p_hit = 4'b0100; p_dirty = 4'b0000;
    n = 0; fill_cycles = 0; vin_cnt = 0; vic = '0; vin_off = '0;
    while (!p_done && n < 40) begin
      tick();
      n++;
      if (n == 1) p_enable = 1'b0;
      if (p_mem_rd || p_cache_write) fill_cycles++;
      if (p_cache_write && !p_cache_comp) vic = p_way_sel;
      if (p_cache_valid_in) begin
        vin_cnt++;
        vin_off = p_cache_offset;
      end
    end
    check("sw_latency", 32'(n), 32'd13);
    check("sw_fill_len", 32'(fill_cycles), 32'd11);
    check("sw_victim", 32'(vic), 32'h4);
    check("sw_vin_cnt", 32'(vin_cnt), 32'd1);
    check("sw_vin_off", 32'(vin_off), 32'd7);
    check("sw_cache_hit", 32'(p_cache_hit), 32'd0);
    check("sw_err", 32'(p_err), 32'd0);
    tick();
    check("sw_idle", 32'(p_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
